// File: rtl/layer_result_serializer_pkg.sv
// Shared constants, types and helpers for the layer result serializer.
// Node results are two's-complement and pass through the serializer untouched.
package nn_pkg;

  localparam int DW      = 8;
  localparam int N_NODES = 16;
  localparam int IDX_W   = $clog2(N_NODES);
  localparam int CNT_W   = $clog2(N_NODES) + 1;
  localparam int NACT_W  = 5;

  typedef logic signed [DW-1:0] act_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_t;

  // A capture is only meaningful for 1..N_NODES nodes.
  function automatic logic count_ok(input logic [NACT_W-1:0] n);
    return (n != '0) && (int'(n) <= N_NODES);
  endfunction

endpackage

// File: rtl/layer_result_serializer_if.sv
// Capture bus from the array plus the serial element stream to the next layer.
// master = layer controller / stream consumer, slave = the serializer.
interface layer_result_serializer_if;
  import nn_pkg::*;

  logic                      capture;
  logic [N_NODES*DW-1:0]     results;
  logic [NACT_W-1:0]         n_active;
  act_t                      x_data;
  logic                      x_valid;
  logic                      x_ready;
  logic                      x_last;
  logic                      busy;
  logic                      overrun;

  modport master (
    output capture, results, n_active, x_ready,
    input  x_data, x_valid, x_last, busy, overrun
  );

  modport slave (
    input  capture, results, n_active, x_ready,
    output x_data, x_valid, x_last, busy, overrun
  );

endinterface

// File: rtl/layer_result_serializer.sv
// Latches one layer's parallel node results and replays them as a handshaked
// serial stream; a capture on the final handshake chains the next layer with no bubble.
module layer_result_serializer
  import nn_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  layer_result_serializer_if.slave  io
);

  ser_state_t state_q, state_d;
  act_t       buf_q [N_NODES];
  act_t       buf_d [N_NODES];
  cnt_t       idx_q, idx_d;
  cnt_t       cnt_q, cnt_d;
  act_t       x_data_q, x_data_d;
  logic       x_valid_q, x_valid_d;
  logic       x_last_q, x_last_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic       hs;
  logic       cap_ok;
  logic       load;

  always_comb begin
    hs        = x_valid_q && io.x_ready;
    cap_ok    = io.capture && count_ok(io.n_active);
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cap_ok) begin
          load = 1'b1;
        end else begin
          overrun_d = io.capture;
        end
      end
      STREAM: begin
        // Only the final handshake frees the buffer for a new capture.
        if (hs && x_last_q) begin
          if (cap_ok) begin
            load = 1'b1;
          end else begin
            state_d   = IDLE;
            overrun_d = io.capture;
          end
        end else begin
          overrun_d = io.capture;
          if (hs) begin
            idx_d = idx_q + cnt_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      for (int i = 0; i < N_NODES; i++) begin
        buf_d[i] = act_t'(io.results[i*DW +: DW]);
      end
      cnt_d   = cnt_t'(io.n_active);
      idx_d   = '0;
      state_d = STREAM;
    end

    // Outputs are registered from the next-state view so they line up with state_q.
    x_valid_d = (state_d == STREAM);
    busy_d    = (state_d == STREAM);
    x_last_d  = (state_d == STREAM) && (idx_d == cnt_d - cnt_t'(1));
    x_data_d  = buf_d[idx_d[IDX_W-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      buf_q     <= '{default: '0};
      idx_q     <= '0;
      cnt_q     <= '0;
      x_data_q  <= '0;
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      x_data_q  <= x_data_d;
      x_valid_q <= x_valid_d;
      x_last_q  <= x_last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign io.x_data  = x_data_q;
  assign io.x_valid = x_valid_q;
  assign io.x_last  = x_last_q;
  assign io.busy    = busy_q;
  assign io.overrun = overrun_q;

endmodule

// File: tb/tb_layer_result_serializer.sv
// Bench for layer_result_serializer: directed scenarios plus a randomized run,
// all scored against a queue-based model of the emitted stream.
module tb_layer_result_serializer;
  import nn_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_result_serializer_if io();

  layer_result_serializer dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: elements still owed to the consumer, front = element on the bus.
  act_t mq[$];
  bit   m_ovr;

  function automatic logic [3:0] exp_ctl();
    logic v;
    v = (mq.size() != 0);
    return {v, mq.size() == 1, v, m_ovr};
  endfunction

  function automatic logic [N_NODES*DW-1:0] pack(input act_t v [N_NODES]);
    logic [N_NODES*DW-1:0] r;
    for (int i = 0; i < N_NODES; i++) r[i*DW +: DW] = v[i];
    return r;
  endfunction

  function automatic logic [N_NODES*DW-1:0] rand_res();
    logic [N_NODES*DW-1:0] r;
    for (int i = 0; i < N_NODES; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Drives one clock cycle and advances the model across that edge.
  task automatic cycle(input bit cap, input logic [NACT_W-1:0] n,
                       input logic [N_NODES*DW-1:0] res, input bit rdy);
    bit hs;
    io.capture  = cap;
    io.n_active = n;
    io.results  = res;
    io.x_ready  = rdy;
    hs = (mq.size() != 0) && rdy;
    if (hs) void'(mq.pop_front());
    m_ovr = 1'b0;
    if (cap) begin
      if (int'(n) >= 1 && int'(n) <= N_NODES && mq.size() == 0) begin
        for (int i = 0; i < int'(n); i++) mq.push_back(act_t'(res[i*DW +: DW]));
      end else begin
        m_ovr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    io.capture = 1'b0;
  endtask

  task automatic test_reset();
    io.capture = 1'b0; io.n_active = '0; io.results = '0; io.x_ready = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({io.x_valid, io.x_last, io.busy, io.overrun, io.x_data} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_values got=%h want=000",
               {io.x_valid, io.x_last, io.busy, io.overrun, io.x_data});
    end
    mq.delete(); m_ovr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b0, '0, '0, 1'b1);
    n_tests++;
    if ({io.x_valid, io.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b want=00", {io.x_valid, io.busy});
    end
  endtask

  task automatic test_full_layer();
    act_t v [N_NODES];
    for (int i = 0; i < N_NODES; i++) v[i] = act_t'(i - 8);
    for (int c = 0; c <= N_NODES; c++) begin
      cycle(c == 0, (c == 0) ? 5'd16 : 5'd0, pack(v), 1'b1);
      n_tests++;
      if (c < N_NODES) begin
        if ({io.x_valid, io.x_last, io.busy} !== {1'b1, c == N_NODES - 1, 1'b1} ||
            io.x_data !== act_t'(c - 8)) begin
          n_fail++;
          $display("FAIL full_layer[%0d] got v/l/b=%b data=%0d want data=%0d last=%0d",
                   c, {io.x_valid, io.x_last, io.busy}, io.x_data, c - 8, c == N_NODES - 1);
        end
      end else if ({io.x_valid, io.busy, io.x_last} !== 3'b000) begin
        n_fail++;
        $display("FAIL full_layer_end got v/b/l=%b want=000", {io.x_valid, io.busy, io.x_last});
      end
    end
  endtask

  task automatic test_backpressure();
    act_t v [N_NODES];
    bit   rdy [5]  = '{1, 0, 0, 1, 1};
    int   expd [5] = '{-128, -128, -128, 5, 0};
    bit   expv [5] = '{1, 1, 1, 1, 0};
    bit   expl [5] = '{0, 0, 0, 1, 0};
    for (int i = 0; i < N_NODES; i++) v[i] = act_t'($urandom);
    v[0] = 8'sd127; v[1] = -8'sd128; v[2] = 8'sd5;
    cycle(1'b1, 5'd3, pack(v), 1'b0);
    n_tests++;
    if (io.x_valid !== 1'b1 || io.x_data !== 8'sd127 || io.x_last !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first got v=%b data=%0d l=%b want v=1 data=127 l=0",
               io.x_valid, io.x_data, io.x_last);
    end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 5'd9, rand_res(), rdy[c]);
      n_tests++;
      if (io.x_valid !== expv[c] || io.x_last !== expl[c] ||
          (expv[c] && io.x_data !== act_t'(expd[c]))) begin
        n_fail++;
        $display("FAIL bp_step[%0d] got v=%b l=%b data=%0d want v=%b l=%b data=%0d",
                 c, io.x_valid, io.x_last, io.x_data, expv[c], expl[c], expd[c]);
      end
    end
  endtask

  task automatic test_bad_count();
    logic [NACT_W-1:0] bad [2] = '{5'd0, 5'd17};
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, bad[k], rand_res(), 1'b1);
      n_tests++;
      if ({io.overrun, io.x_valid, io.busy} !== 3'b100) begin
        n_fail++;
        $display("FAIL bad_count_%0d got o/v/b=%b want=100", bad[k], {io.overrun, io.x_valid, io.busy});
      end
      cycle(1'b0, '0, '0, 1'b1);
      n_tests++;
      if ({io.overrun, io.x_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL bad_count_%0d_after got o/v=%b want=00", bad[k], {io.overrun, io.x_valid});
      end
    end
  endtask

  task automatic test_overrun_stream();
    logic [N_NODES*DW-1:0] a;
    act_t want [4];
    a = rand_res();
    for (int i = 0; i < 4; i++) want[i] = act_t'(a[i*DW +: DW]);
    cycle(1'b1, 5'd4, a, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      // Capture lands while element 2 is on the bus.
      cycle(c == 3, 5'd4, rand_res(), 1'b1);
      n_tests++;
      if (io.overrun !== (c == 3) || (c < 4 && io.x_data !== want[c]) ||
          io.x_valid !== (c < 4) || io.x_last !== (c == 3)) begin
        n_fail++;
        $display("FAIL ovr_stream[%0d] got o=%b v=%b l=%b data=%0d want o=%b data=%0d",
                 c, io.overrun, io.x_valid, io.x_last, io.x_data, c == 3, (c < 4) ? want[c] : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    act_t v [N_NODES];
    act_t w [N_NODES];
    for (int i = 0; i < N_NODES; i++) begin v[i] = act_t'(i + 1); w[i] = act_t'(i + 9); end
    cycle(1'b1, 5'd3, pack(v), 1'b1);
    cycle(1'b0, 5'd0, '0, 1'b1);
    cycle(1'b0, 5'd0, '0, 1'b1);
    n_tests++;
    if (io.x_data !== 8'sd3 || io.x_last !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_lastA got data=%0d l=%b want data=3 l=1", io.x_data, io.x_last);
    end
    cycle(1'b1, 5'd2, pack(w), 1'b1);
    n_tests++;
    if ({io.x_valid, io.x_last, io.overrun} !== 3'b100 || io.x_data !== 8'sd9) begin
      n_fail++;
      $display("FAIL b2b_first got v/l/o=%b data=%0d want 100 data=9",
               {io.x_valid, io.x_last, io.overrun}, io.x_data);
    end
    cycle(1'b0, 5'd0, '0, 1'b1);
    n_tests++;
    if ({io.x_valid, io.x_last} !== 2'b11 || io.x_data !== 8'sd10) begin
      n_fail++;
      $display("FAIL b2b_second got v/l=%b data=%0d want 11 data=10", {io.x_valid, io.x_last}, io.x_data);
    end
    cycle(1'b0, 5'd0, '0, 1'b1);
    n_tests++;
    if ({io.x_valid, io.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end got v/b=%b want=00", {io.x_valid, io.busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [N_NODES*DW-1:0] a;
    cycle(1'b1, 5'd16, rand_res(), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1);
    n_tests++;
    if (io.x_data !== mq[0] || mq.size() != 11) begin
      n_fail++;
      $display("FAIL reset_mid_pos got data=%0d want=%0d", io.x_data, mq[0]);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({io.x_valid, io.busy, io.x_last, io.x_data} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async got v/b/l=%b data=%0d want 000 data=0",
               {io.x_valid, io.busy, io.x_last}, io.x_data);
    end
    mq.delete(); m_ovr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    a = rand_res();
    cycle(1'b1, 5'd4, a, 1'b0);
    n_tests++;
    if (io.x_valid !== 1'b1 || io.x_data !== act_t'(a[DW-1:0])) begin
      n_fail++;
      $display("FAIL reset_mid_restart got v=%b data=%0d want v=1 data=%0d",
               io.x_valid, io.x_data, act_t'(a[DW-1:0]));
    end
    while (mq.size() != 0) cycle(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 5) == 0, NACT_W'($urandom_range(0, 17)), rand_res(),
            $urandom_range(0, 3) != 0);
      n_tests++;
      if ({io.x_valid, io.x_last, io.busy, io.overrun} !== exp_ctl() ||
          (mq.size() != 0 && io.x_data !== mq[0])) begin
        n_fail++;
        $display("FAIL random[%0d] got v/l/b/o=%b data=%0d want=%b data=%0d",
                 c, {io.x_valid, io.x_last, io.busy, io.overrun}, io.x_data, exp_ctl(),
                 (mq.size() != 0) ? mq[0] : act_t'(0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_backpressure();
    test_bad_count();
    test_overrun_stream();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
